// File: rtl/pooling_pkg.sv
// Shared types and encodings for the pooling window feeder and its pooling partner.
package pooling_pkg;
   localparam int WORD_IL = 4;
   localparam int WORD_FL = 16;

   typedef logic signed [WORD_IL+WORD_FL-1:0] word_t;

   localparam logic [1:0] POOL_IDLE = 2'b00;
   localparam logic [1:0] POOL_BUSY = 2'b01;
   localparam logic [1:0] POOL_DONE = 2'b10;

   localparam logic [1:0] MODE_MAX  = 2'b00;
   localparam logic [1:0] MODE_MEAN = 2'b01;
   localparam logic [1:0] MODE_MIN  = 2'b10;

   typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} feed_state_e;
endpackage

// File: rtl/pooling_window_feeder_sr.sv
// Window shift register: newest word enters at the top, index 0 holds the oldest.
module pool_window_sr
   import pooling_pkg::*;
#(
   parameter type elem_t = word_t,
   parameter int  DEPTH  = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clear_i,
   input  logic  shift_i,
   input  elem_t din_i,
   output elem_t win_o [DEPTH]
);
   elem_t win_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      end else if (shift_i) begin
         for (int i = 0; i < DEPTH-1; i++) win_q[i] <= win_q[i+1];
         win_q[DEPTH-1] <= din_i;
      end
   end

   assign win_o = win_q;
endmodule

// File: rtl/pooling_window_feeder.sv
// Builds strided windows from a word stream, launches one pooling op per window
// and forwards each pooling result downstream.
//   state | meaning
//   FILL  | accepting words until a window completes
//   ISSUE | window ready, waiting for pooling idle to pulse launch
//   WAIT  | pooling busy, waiting for done to capture result
//   DRAIN | result held on out_* until downstream accepts
module pooling_window_feeder
   import pooling_pkg::*;
#(
   parameter int IL     = 4,
   parameter int FL     = 16,
   parameter int size   = 4,
   parameter int width  = $clog2(size),
   parameter int STRIDE = size
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic signed [IL+FL-1:0]          in_data,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             in_last,
   input  logic [1:0]                       cfg_mode,
   output logic [size-1:0][IL+FL-1:0]       pool_im,
   output logic                             pool_input_ready,
   output logic [1:0]                       pool_mode,
   input  logic [1:0]                       pool_state,
   input  logic signed [IL+FL-1:0]          pool_om,
   output logic                             pool_output_taken,
   output logic signed [IL+FL-1:0]          out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_last,
   output logic                             trunc_err
);
   // One extra bit so the fill counter can hold the value size itself.
   localparam int CW = width + 1;
   localparam logic [CW-1:0] SIZE_C   = CW'(size);
   localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);

   typedef logic signed [IL+FL-1:0] data_t;

   feed_state_e    state_q;
   logic           in_ready_q, row_start_q, last_q;
   logic           out_valid_q, out_last_q, trunc_q;
   logic [1:0]     mode_q;
   logic [CW-1:0]  fill_q, stride_q;
   data_t          out_data_q;
   data_t          win [size];

   logic           accept, win_done, win_clear;
   logic [CW-1:0]  fill_d, stride_d;

   assign accept   = in_ready_q && in_valid;
   assign fill_d   = (fill_q == SIZE_C) ? fill_q : fill_q + 1'b1;
   assign stride_d = stride_q + 1'b1;
   assign win_done = (fill_q != SIZE_C) ? (fill_d == SIZE_C) : (stride_d == STRIDE_C);
   assign win_clear = accept && in_last && !win_done;

   pool_window_sr #(.elem_t(data_t), .DEPTH(size)) u_win (
      .clk     (clk),
      .rst_n   (reset),
      .clear_i (win_clear),
      .shift_i (accept),
      .din_i   (in_data),
      .win_o   (win)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= FILL;
         in_ready_q  <= 1'b0;
         row_start_q <= 1'b1;
         last_q      <= 1'b0;
         fill_q      <= '0;
         stride_q    <= '0;
         mode_q      <= MODE_MAX;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         trunc_q     <= 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  if (row_start_q) mode_q <= cfg_mode;
                  row_start_q <= in_last;
                  fill_q      <= fill_d;
                  stride_q    <= stride_d;
                  if (win_done) begin
                     state_q    <= ISSUE;
                     in_ready_q <= 1'b0;
                     last_q     <= in_last;
                     stride_q   <= '0;
                     if (in_last) fill_q <= '0;
                  end else if (in_last) begin
                     fill_q   <= '0;
                     stride_q <= '0;
                     trunc_q  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (pool_state == POOL_IDLE) state_q <= WAIT;
            end
            WAIT: begin
               if (pool_state == POOL_DONE) begin
                  out_data_q  <= pool_om;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_q;
                  state_q     <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   // Launch and take are decoded from the live pooling state so each lands in the same cycle.
   assign pool_input_ready  = (state_q == ISSUE) && (pool_state == POOL_IDLE);
   assign pool_output_taken = (state_q == WAIT)  && (pool_state == POOL_DONE);

   for (genvar i = 0; i < size; i++) begin : g_im
      assign pool_im[i] = win[i];
   end

   assign in_ready  = in_ready_q;
   assign pool_mode = mode_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign trunc_err = trunc_q;
endmodule
